// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline stall/flush/redirect controller with saturating perf counters.
// Define MUL_STALL_EN to enable the multi-cycle multiply freeze (MUL_WAIT state).
module hazard_sequencer #(
    parameter  int unsigned MUL_LAT = 3,
    localparam int unsigned OP_W    = 6,
    localparam int unsigned REG_W   = 5,
    localparam int unsigned SEL_W   = 2,
    localparam int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [OP_W-1:0]  ID_op_i,
    input  logic [REG_W-1:0] ID_rs_i,
    input  logic [REG_W-1:0] ID_rt_i,
    input  logic [SEL_W-1:0] PC_ctrl_i,
    input  logic             is_equal_i,
    input  logic             EX_mem_read_i,
    input  logic             EX_reg_we_i,
    input  logic [REG_W-1:0] EX_dst_i,
    input  logic             EX_is_mul_i,
    output logic             PC_we_o,
    output logic             IF_ID_we_o,
    output logic             ID_EX_we_o,
    output logic             IF_flush_o,
    output logic             ID_EX_bubble_o,
    output logic             EX_MEM_bubble_o,
    output logic [SEL_W-1:0] PC_sel_o,
    output logic             mul_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [OP_W-1:0] R_OP    = 6'h00;
    localparam logic [OP_W-1:0] J_OP    = 6'h02;
    localparam logic [OP_W-1:0] BEQ_OP  = 6'h04;
    localparam logic [OP_W-1:0] ADDI_OP = 6'h08;
    localparam logic [OP_W-1:0] MUL_OP  = 6'h1C;
    localparam logic [OP_W-1:0] LW_OP   = 6'h23;
    localparam logic [OP_W-1:0] SW_OP   = 6'h2B;

    localparam logic [SEL_W-1:0] SEL_SEQ    = 2'b00;
    localparam logic [SEL_W-1:0] SEL_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] SEL_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] CTRL_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] CTRL_BRANCH = 2'b11;

`ifdef MUL_STALL_EN
    localparam int unsigned     MCNT_W   = 4;
    localparam logic [MCNT_W-1:0] MUL_LOAD = MCNT_W'(MUL_LAT - 2);

    typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, MUL_WAIT = 2'd2} state_t;

    logic [MCNT_W-1:0] cnt_q, cnt_d;
    logic              mul_done_q, mul_done_d;
    logic              mul_start;
`else
    typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1} state_t;

    logic mul_unused;
    assign mul_unused = EX_is_mul_i & (MUL_LAT != 0);
`endif

    state_t state_q, state_d;
    logic   uses_rs, uses_rt, dst_match, load_use, branch_haz;

    // Which source fields the ID instruction actually reads; unknown opcodes read none.
    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        case (ID_op_i)
            R_OP, MUL_OP, BEQ_OP, SW_OP: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            ADDI_OP, LW_OP: uses_rs = 1'b1;
            J_OP:           uses_rs = 1'b0;
            default:        uses_rs = 1'b0;
        endcase
    end

    assign dst_match  = (EX_dst_i != '0)
                      && ((uses_rs && (EX_dst_i == ID_rs_i)) || (uses_rt && (EX_dst_i == ID_rt_i)));
    assign load_use   = EX_mem_read_i && dst_match;
    assign branch_haz = (PC_ctrl_i == CTRL_BRANCH) && EX_reg_we_i && dst_match;

`ifdef MUL_STALL_EN
    assign mul_start = EX_is_mul_i && !mul_done_q && (MUL_LAT > 1);
`endif

    // Next state and combinational pipeline controls, highest-priority event first.
    always_comb begin
        state_d         = state_q;
        PC_we_o         = 1'b1;
        IF_ID_we_o      = 1'b1;
        ID_EX_we_o      = 1'b1;
        IF_flush_o      = 1'b0;
        ID_EX_bubble_o  = 1'b0;
        EX_MEM_bubble_o = 1'b0;
        PC_sel_o        = SEL_SEQ;
        mul_busy_o      = 1'b0;
`ifdef MUL_STALL_EN
        cnt_d      = cnt_q;
        mul_done_d = mul_done_q;
`endif
        unique case (state_q)
            INIT: begin
                IF_flush_o     = 1'b1;
                ID_EX_bubble_o = 1'b1;
                state_d        = RUN;
            end
            RUN: begin
`ifdef MUL_STALL_EN
                if (mul_start) begin
                    PC_we_o         = 1'b0;
                    IF_ID_we_o      = 1'b0;
                    ID_EX_we_o      = 1'b0;
                    EX_MEM_bubble_o = 1'b1;
                    mul_busy_o      = 1'b1;
                    // A two-cycle multiply is fully covered by this single frozen cycle.
                    if (MUL_LAT == 2) begin
                        mul_done_d = 1'b1;
                    end else begin
                        cnt_d   = MUL_LOAD;
                        state_d = MUL_WAIT;
                    end
                end else
`endif
                if (load_use || branch_haz) begin
                    PC_we_o        = 1'b0;
                    IF_ID_we_o     = 1'b0;
                    ID_EX_bubble_o = 1'b1;
                end else if (PC_ctrl_i == CTRL_JUMP) begin
                    PC_sel_o   = SEL_JUMP;
                    IF_flush_o = 1'b1;
                end else if ((PC_ctrl_i == CTRL_BRANCH) && is_equal_i) begin
                    PC_sel_o   = SEL_BRANCH;
                    IF_flush_o = 1'b1;
                end
            end
`ifdef MUL_STALL_EN
            // Counter holds the remaining frozen cycles including this one.
            MUL_WAIT: begin
                PC_we_o         = 1'b0;
                IF_ID_we_o      = 1'b0;
                ID_EX_we_o      = 1'b0;
                EX_MEM_bubble_o = 1'b1;
                mul_busy_o      = 1'b1;
                cnt_d           = cnt_q - MCNT_W'(1);
                if (cnt_q <= MCNT_W'(1)) begin
                    cnt_d      = '0;
                    mul_done_d = 1'b1;
                    state_d    = RUN;
                end
            end
`endif
            default: state_d = INIT;
        endcase
`ifdef MUL_STALL_EN
        if (ID_EX_we_o) begin
            mul_done_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= INIT;
`ifdef MUL_STALL_EN
            cnt_q      <= '0;
            mul_done_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MUL_STALL_EN
            cnt_q      <= cnt_d;
            mul_done_q <= mul_done_d;
`endif
        end
    end

    // Saturating performance counters; the INIT flush is not a pipeline event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (!PC_we_o && !(&stall_cnt_o)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (IF_flush_o && (state_q != INIT) && !(&flush_cnt_o)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule
